// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one reset-less, ready-less uart_tx (1 bit/clk) among N_REQ byte sources.
// Holds din from accept until bit 7 is sampled and only pulses start once the transmitter is idle again.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 0,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_din,
  output logic               tx_start,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic               done
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     din_q, din_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic [7:0]     sel_byte;
  logic           grant;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  assign grant = (state_q == S_IDLE) && en && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant && (win == IDW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    case (state_q)
      // The transmitter has no reset, so let any frame it was sending run out first.
      S_FLUSH: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_IDLE: begin
        if (grant) begin
          din_d   = sel_byte;
          gid_d   = win;
          ptr_d   = win;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        cnt_d   = 8'd8;
      end
      // din must stay put until the transmitter has sampled bit 7 on the cnt==0 cycle.
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          cnt_d   = 8'(GAP_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = S_FLUSH;
        cnt_d   = 8'd9;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FLUSH;
      cnt_q   <= 8'd9;
      din_q   <= 8'h00;
      gid_q   <= IDW'(N_REQ - 1);
      ptr_q   <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign tx_din   = din_q;
  assign tx_start = (state_q == S_SEND);
  assign busy     = (state_q != S_IDLE);
  assign grant_id = gid_q;
  assign done     = (state_q == S_WAIT) && (cnt_q == 8'd0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed stimulus queues expected grants/bytes, monitors at negedge pop and compare.
// Includes a behavioural uart_tx (no reset, 1 bit/clk) and a line receiver to decode the serial bytes.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en;
  logic [N-1:0]   req_valid, vg;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready, rdy_g;
  logic [7:0]     tx_din, din_g;
  logic           tx_start, start_g, busy, busy_g, done, done_g;
  logic [1:0]     grant_id, gid_g;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_din(tx_din), .tx_start(tx_start), .busy(busy),
    .grant_id(grant_id), .done(done)
  );

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .rst(rst), .en(en), .req_valid(vg), .req_data(req_data),
    .req_ready(rdy_g), .tx_din(din_g), .tx_start(start_g), .busy(busy_g),
    .grant_id(gid_g), .done(done_g)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx: start sampled at e1, start bit from e2, data e3..e10, stop from e11.
  logic line = 1'b1;
  int   ucnt = 0;
  always @(posedge clk) begin
    if (ucnt == 0) begin
      if (tx_start) ucnt <= 1;
    end else if (ucnt == 1) begin
      line <= 1'b0;
      ucnt <= 2;
    end else if (ucnt <= 9) begin
      line <= tx_din[3'(ucnt - 2)];
      ucnt <= ucnt + 1;
    end else begin
      line <= 1'b1;
      ucnt <= 0;
    end
  end

  typedef struct { int id; int at; } acc_t;
  acc_t exp_acc[$];
  int   exp_byte[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_a(input int id, input int at);
    acc_t e;
    e.id = id;
    e.at = at;
    exp_acc.push_back(e);
  endtask

  function automatic logic [7:0] get_byte(input int i);
    logic [8*N-1:0] t;
    t = req_data >> (8 * i);
    return t[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main monitor: accepts, grant_id, start/done timing, and decoded line bytes.
  int start_cnt = 0;
  int done_cnt = 0;
  initial begin
    acc_t e;
    logic [N-1:0] acc;
    int last_acc = -100;
    logic [7:0] last_din = 8'h00;
    int pend_gid = -1;
    int rx_st = 0;
    int rx_n = 0;
    logic [7:0] rx_b = 8'h00;
    int eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        acc = req_valid & req_ready;
        if (pend_gid >= 0) begin
          check("grant_id", int'(grant_id), pend_gid);
          pend_gid = -1;
        end
        if (acc != '0) begin
          if (exp_acc.size() == 0) begin
            check("unexpected_accept", int'(acc), 0);
          end else begin
            e = exp_acc.pop_front();
            check("accept_onehot", int'(req_ready), 1 << e.id);
            check("accept_cycle", cyc, e.at);
            last_din = get_byte(e.id);
            pend_gid = e.id;
          end
          last_acc = cyc;
        end
        if (tx_start) begin
          start_cnt++;
          check("start_cycle", cyc, last_acc + 1);
        end
        if (done) begin
          done_cnt++;
          check("done_cycle", cyc, last_acc + 10);
          check("din_at_done", int'(tx_din), int'(last_din));
        end
      end
      case (rx_st)
        0: if (line == 1'b0) begin rx_st = 1; rx_n = 0; end
        1: begin
          rx_b = {line, rx_b[7:1]};
          rx_n++;
          if (rx_n == 8) rx_st = 2;
        end
        default: begin
          check("rx_stop_bit", int'(line), 1);
          if (exp_byte.size() == 0) begin
            check("unexpected_byte", int'(rx_b), -1);
          end else begin
            eb = exp_byte.pop_front();
            if (eb >= 0) check("line_byte", int'(rx_b), eb);
          end
          rx_st = 0;
        end
      endcase
    end
  end

  // Monitor for the GAP_CYCLES=3 instance, requester 2 only.
  int g_acc_n = 0;
  initial begin
    int g_last = -1;
    int g_blc = 0;
    int g_err = 0;
    bit g_inframe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!busy_g) g_blc++;
        if ((vg & rdy_g) != '0) begin
          check("g_onehot", int'(rdy_g), 4);
          if (g_last >= 0) begin
            check("g_period", cyc - g_last, 14);
            check("g_busy_low", g_blc, 1);
          end
          g_blc = 0;
          g_last = cyc;
          g_acc_n++;
          g_inframe = 1'b1;
          g_err = 0;
        end else if (g_inframe) begin
          if (din_g != 8'h32) g_err++;
          if (start_g) check("g_start_cycle", cyc, g_last + 1);
          if (done_g) begin
            check("g_done_cycle", cyc, g_last + 10);
            check("g_din_stable_errs", g_err, 0);
            check("g_grant_id", int'(gid_g), 2);
            g_inframe = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    int nrdy;
    int viol;
    rst = 1'b1;
    en = 1'b1;
    req_valid = '0;
    vg = '0;
    req_data = {8'h33, 8'h32, 8'h31, 8'hA5};

    // Test 1: single requester 0, byte A5 held
    req_valid = 4'b0001;
    tick(3);
    rst = 1'b0;
    t0 = cyc;
    check("rst_tx_din", int'(tx_din), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_grant_id", int'(grant_id), 3);
    check("rst_busy", int'(busy), 1);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(req_ready), 0);
    exp_a(0, t0 + 10); exp_a(0, t0 + 21);
    exp_byte.push_back(8'hA5); exp_byte.push_back(8'hA5);
    tick(25);
    req_valid = '0;
    tick(15);

    // Test 2: all valid after reset, grants 0,1,2,3,0
    req_data[7:0] = 8'h30;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t0 = cyc;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_a(k % 4, t0 + 10 + 11 * k);
      exp_byte.push_back(8'h30 + (k % 4));
    end
    tick(58);
    req_valid = '0;
    tick(15);

    // Test 3: GAP_CYCLES=3 instance, requester 2 only
    vg = 4'b0100;
    tick(33);
    vg = '0;
    tick(20);
    check("g_accepts", g_acc_n, 3);

    // Test 4: en=0 blocks grants; en=1 grants at once; en dropped mid-WAIT
    en = 1'b0;
    req_valid = 4'b1111;
    nrdy = 0;
    repeat (50) begin
      tick(1);
      if (req_ready != '0) nrdy++;
    end
    check("en0_no_ready", nrdy, 0);
    en = 1'b1;
    t0 = cyc;
    exp_a(1, t0); exp_a(2, t0 + 11);
    exp_byte.push_back(8'h31); exp_byte.push_back(8'h32);
    tick(16);
    en = 1'b0;
    tick(30);
    check("en0_idle_busy", int'(busy), 0);
    req_valid = '0;
    en = 1'b1;

    // Test 6: requesters 1 and 3 with pointer parked at 1
    req_valid = 4'b0010;
    t0 = cyc;
    exp_a(1, t0);
    tick(5);
    req_valid = 4'b1010;
    exp_a(3, t0 + 11); exp_a(1, t0 + 22); exp_a(3, t0 + 33); exp_a(1, t0 + 44);
    exp_byte.push_back(8'h31); exp_byte.push_back(8'h33); exp_byte.push_back(8'h31);
    exp_byte.push_back(8'h33); exp_byte.push_back(8'h31);
    tick(32);
    req_valid = 4'b0010;
    req_data[31:24] = 8'hFF;
    tick(11);
    req_valid = '0;
    tick(15);

    // Test 5: reset 4 cycles after tx_start, then requester 0 wins first
    req_valid = 4'b1000;
    t0 = cyc;
    exp_a(3, t0);
    exp_byte.push_back(-1);
    tick(5);
    rst = 1'b1;
    req_valid = 4'b1111;
    tick(1);
    rst = 1'b0;
    exp_a(0, t0 + 16); exp_a(1, t0 + 27);
    exp_byte.push_back(8'h30); exp_byte.push_back(8'h31);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start != 1'b0 || busy != 1'b1 || req_ready != '0) viol++;
      tick(1);
    end
    check("flush_quiet", viol, 0);
    tick(15);
    req_valid = '0;
    tick(15);

    check("acc_queue_left", exp_acc.size(), 0);
    check("byte_queue_left", exp_byte.size(), 0);
    check("start_count", start_cnt, 17);
    check("done_count", done_cnt, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
